// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: load-use bubbles, ID redirect flushes, data-memory wait stalls.
// Enables are same-cycle combinational; counters/err register on the edge; a missing mem ack freezes the pipe until timeout.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RT_i,
    input  logic [4:0]       IFID_RS_i,
    input  logic [4:0]       IFID_RT_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             PC_Write_o,
    output logic             IFID_Write_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_Bubble_o,
    output logic             pipe_stall_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    // The request cycle is the first stall cycle, so ERROR is entered once the
    // counter would reach MEM_TIMEOUT-1, giving MEM_TIMEOUT stall cycles total.
    localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic       load_use;
    logic       redirect;
    logic       hold;

    assign load_use = IDEX_MemRead_i && (IDEX_RT_i != 5'd0) &&
                      ((IDEX_RT_i == IFID_RS_i) || (IDEX_RT_i == IFID_RT_i));
    assign redirect = branch_taken_i || jump_i;

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        hold          = 1'b0;
        PC_Write_o    = 1'b0;
        IFID_Write_o  = 1'b0;
        IFID_Flush_o  = 1'b0;
        IDEX_Bubble_o = 1'b0;
        pipe_stall_o  = 1'b0;

        if (rst_i) begin
            state_nxt    = S_RUN;
            wait_cnt_nxt = '0;
        end else if (!start_i) begin
            pipe_stall_o = 1'b1;
        end else begin
            unique case (state)
                S_RUN: begin
                    hold = mem_req_i && !mem_ack_i;
                    if (hold) begin
                        state_nxt = S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    hold = !mem_ack_i;
                    if (hold) begin
                        wait_cnt_nxt = wait_cnt + 8'd1;
                        if (wait_cnt == WAIT_LAST) begin
                            state_nxt = S_ERROR;
                        end
                    end else begin
                        state_nxt    = S_RUN;
                        wait_cnt_nxt = '0;
                    end
                end
                S_ERROR: begin
                    hold = 1'b1;
                end
                default: begin
                    hold      = 1'b1;
                    state_nxt = S_RUN;
                end
            endcase

            // A redirect under a bubble or stall is dropped; ID keeps the branch and re-raises it.
            if (hold) begin
                pipe_stall_o = 1'b1;
            end else if (load_use) begin
                IDEX_Bubble_o = 1'b1;
            end else begin
                PC_Write_o   = 1'b1;
                IFID_Write_o = 1'b1;
                IFID_Flush_o = redirect;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_RUN;
            wait_cnt    <= '0;
            err_o       <= 1'b0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state_nxt == S_ERROR) begin
                err_o <= 1'b1;
            end
            if (start_i && (state != S_ERROR) && !PC_Write_o && (stall_cnt_o != CNT_MAX)) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (IFID_Flush_o && (flush_cnt_o != CNT_MAX)) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: per-cycle reference model check plus hand-computed spot values.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    localparam int L_PCW    = 0;
    localparam int L_IFW    = 1;
    localparam int L_FLUSH  = 2;
    localparam int L_BUB    = 3;
    localparam int L_PSTALL = 4;
    localparam int L_ERR    = 5;
    localparam int L_SCNT   = 6;
    localparam int L_FCNT   = 7;

    logic             clk;
    logic             rst;
    logic             start;
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             branch_taken;
    logic             jump;
    logic             mem_req;
    logic             mem_ack;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_stall;
    logic             err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int    checks = 0;
    int    errors = 0;
    bit    chk_en = 0;
    bit    lit_vld = 0;
    int    lit_sel = 0;
    int    lit_val = 0;
    string lit_tag = "";

    // Reference model: memory access tracked as count of stall cycles it has cost so far.
    bit m_busy = 0;
    int m_waited = 0;
    bit m_err = 0;
    int m_stall = 0;
    int m_flush = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .IDEX_MemRead_i (idex_memread),
        .IDEX_RT_i      (idex_rt),
        .IFID_RS_i      (ifid_rs),
        .IFID_RT_i      (ifid_rt),
        .branch_taken_i (branch_taken),
        .jump_i         (jump),
        .mem_req_i      (mem_req),
        .mem_ack_i      (mem_ack),
        .PC_Write_o     (pc_write),
        .IFID_Write_o   (ifid_write),
        .IFID_Flush_o   (ifid_flush),
        .IDEX_Bubble_o  (idex_bubble),
        .pipe_stall_o   (pipe_stall),
        .err_o          (err),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            bit e_pc, e_ifw, e_fl, e_bub, e_st, mem_stall, lu;
            logic [31:0] lit_act;
            e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 0; e_st = 0; mem_stall = 0;
            lu = idex_memread && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
            if (rst) begin
                e_st = 0;
            end else if (!start || m_err) begin
                e_st = 1;
            end else begin
                mem_stall = m_busy ? !mem_ack : (mem_req && !mem_ack);
                if (mem_stall) e_st = 1;
                else if (lu) e_bub = 1;
                else begin
                    e_pc = 1; e_ifw = 1; e_fl = branch_taken || jump;
                end
            end

            cmp("pc_write",    32'(pc_write),    32'(e_pc));
            cmp("ifid_write",  32'(ifid_write),  32'(e_ifw));
            cmp("ifid_flush",  32'(ifid_flush),  32'(e_fl));
            cmp("idex_bubble", 32'(idex_bubble), 32'(e_bub));
            cmp("pipe_stall",  32'(pipe_stall),  32'(e_st));
            cmp("err",         32'(err),         32'(m_err));
            cmp("stall_cnt",   32'(stall_cnt),   32'(m_stall));
            cmp("flush_cnt",   32'(flush_cnt),   32'(m_flush));

            if (lit_vld) begin
                case (lit_sel)
                    L_PCW:    lit_act = 32'(pc_write);
                    L_IFW:    lit_act = 32'(ifid_write);
                    L_FLUSH:  lit_act = 32'(ifid_flush);
                    L_BUB:    lit_act = 32'(idex_bubble);
                    L_PSTALL: lit_act = 32'(pipe_stall);
                    L_ERR:    lit_act = 32'(err);
                    L_SCNT:   lit_act = 32'(stall_cnt);
                    default:  lit_act = 32'(flush_cnt);
                endcase
                cmp(lit_tag, lit_act, 32'(lit_val));
            end

            if (rst) begin
                m_busy = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
            end else if (start) begin
                if (!m_err && !e_pc && m_stall < CNT_MAX) m_stall = m_stall + 1;
                if (e_fl && m_flush < CNT_MAX) m_flush = m_flush + 1;
                if (mem_stall) begin
                    m_busy = 1;
                    m_waited = m_waited + 1;
                    if (m_waited == MEM_TIMEOUT) m_err = 1;
                end else if (!m_err) begin
                    m_busy = 0;
                    m_waited = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        lit_vld = 0;
    endtask

    task automatic lit(input int sel, input int val, input string tag);
        lit_sel = sel;
        lit_val = val;
        lit_tag = tag;
        lit_vld = 1;
    endtask

    task automatic clear_in();
        idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
        branch_taken = 0; jump = 0; mem_req = 0; mem_ack = 0;
    endtask

    initial begin
        rst = 1; start = 0;
        clear_in();
        step();
        chk_en = 1;
        step();

        // Hazard-free run
        rst = 0; start = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) lit(L_PCW, 1, "idle_pc_write");
            if (i == 9) lit(L_SCNT, 0, "idle_stall_cnt");
            step();
        end

        // Load-use on rs, then destination r0 which must not stall
        idex_memread = 1; idex_rt = 5; ifid_rs = 5;
        lit(L_BUB, 1, "lu_bubble");
        step();
        clear_in();
        lit(L_SCNT, 1, "lu_stall_cnt");
        step();
        idex_memread = 1; idex_rt = 0; ifid_rs = 0;
        lit(L_PCW, 1, "lu_rt0_pc_write");
        step();
        clear_in();
        step();

        // Branch suppressed by load-use on rt, then taken alone, then a jump
        idex_memread = 1; idex_rt = 7; ifid_rt = 7; branch_taken = 1;
        lit(L_FLUSH, 0, "br_lu_no_flush");
        step();
        idex_memread = 0;
        lit(L_FLUSH, 1, "br_flush");
        step();
        clear_in();
        lit(L_FCNT, 1, "flush_cnt_one");
        step();
        jump = 1;
        step();
        clear_in();
        lit(L_FCNT, 2, "jump_flush_cnt");
        step();

        rst = 1;
        step();
        rst = 0;

        // Memory access acked after 4 stall cycles
        mem_req = 1;
        for (int i = 0; i < 4; i++) step();
        mem_ack = 1;
        lit(L_PSTALL, 0, "ack_cycle_no_stall");
        step();
        clear_in();
        lit(L_SCNT, 4, "mem_stall_cnt");
        step();
        mem_req = 1; mem_ack = 1;
        lit(L_PSTALL, 0, "same_cycle_ack");
        step();
        clear_in();
        lit(L_SCNT, 4, "same_cycle_ack_cnt");
        step();

        // Timeout into ERROR, ack ignored afterwards
        mem_req = 1;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            if (i == MEM_TIMEOUT - 1) lit(L_ERR, 0, "err_before_timeout");
            step();
        end
        mem_req = 0;
        lit(L_ERR, 1, "err_set");
        step();
        mem_ack = 1;
        lit(L_PSTALL, 1, "err_ignores_ack");
        step();
        mem_ack = 0;
        step();
        lit(L_SCNT, 12, "err_no_count");
        step();
        rst = 1;
        step();
        rst = 0;
        lit(L_ERR, 0, "rst_clears_err");
        step();
        lit(L_SCNT, 0, "rst_clears_cnt");
        step();

        // Counter saturation
        idex_memread = 1; idex_rt = 3; ifid_rs = 3;
        for (int i = 0; i < 20; i++) step();
        clear_in();
        lit(L_SCNT, 15, "stall_cnt_sat");
        step();
        branch_taken = 1;
        for (int i = 0; i < 20; i++) step();
        clear_in();
        lit(L_FCNT, 15, "flush_cnt_sat");
        step();

        // Reset during MEM_WAIT
        mem_req = 1;
        for (int i = 0; i < 3; i++) step();
        rst = 1;
        lit(L_PSTALL, 0, "rst_outputs_zero");
        step();
        rst = 0; mem_req = 0;
        lit(L_PSTALL, 0, "rst_mid_wait_run");
        step();

        // start_i=0 freezes, including an ack while waiting
        mem_req = 1;
        step();
        start = 0; mem_ack = 1;
        lit(L_PSTALL, 1, "start0_stall");
        step();
        step();
        lit(L_SCNT, 1, "start0_cnt_hold");
        step();
        start = 1; mem_ack = 0;
        step();
        mem_ack = 1;
        lit(L_PCW, 1, "resume_ack_pc_write");
        step();
        clear_in();
        step();
        step();

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
